// File: rtl/lenet_ctrl_pkg.sv
// Shared types and defaults for the LeNet layer-chain scheduler.
package lenet_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRun,
    StHold,
    StXfer,
    StReply
  } stage_state_e;

  localparam int unsigned DefNumLayers     = 4;
  localparam int unsigned DefTimeoutCycles = 4096;
  localparam int unsigned DefTimeoutW      = 13;
  localparam int unsigned DefFrameCntW     = 16;
  localparam int unsigned LayerIdxW        = 3;
  localparam int unsigned MaxLayers        = 8;

  // Index of the lowest set bit; 0 when none is set.
  function automatic logic [LayerIdxW-1:0] lowest_set(input logic [MaxLayers-1:0] v);
    lowest_set = '0;
    for (int i = MaxLayers - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = LayerIdxW'(i);
    end
  endfunction

endpackage

// File: rtl/layer_stage_ctrl.sv
// Handshake FSM for one layer engine, with a RUN-state watchdog counter.
module layer_stage_ctrl
  import lenet_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned TIMEOUT_W      = DefTimeoutW,
  parameter bit          IS_LAST        = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         go_start,
  input  logic         finished,
  input  logic         release_hold,
  input  logic         freeze,
  input  logic         force_reply,
  output stage_state_e state,
  output logic         enable,
  output logic         reply,
  output logic         timeout
);

  stage_state_e         state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (force_reply) begin
      if (state_q != StIdle) state_d = StReply;
    end else if (!freeze) begin
      unique case (state_q)
        StIdle:  if (go_start) state_d = StStart;
        StStart: state_d = StRun;
        StRun:   if (finished) state_d = StHold;
        StHold:  if (release_hold) state_d = IS_LAST ? StReply : StXfer;
        StXfer:  state_d = StReply;
        StReply: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    // Held at zero outside RUN, so entry to RUN always starts from a clean count.
    cnt_d = cnt_q;
    if (state_q != StRun) begin
      cnt_d = '0;
    end else if (!freeze && !force_reply && !finished) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state   = state_q;
    enable  = (state_q == StStart);
    reply   = (state_q == StReply);
    timeout = (state_q == StRun) && !finished && !freeze && !force_reply &&
              (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  end

endmodule

// File: rtl/lenet_layer_scheduler.sv
// Sequences a chain of layer engines so each layer can hold its own frame, with
// host handshake, per-layer watchdog and a completed-frame counter.
module lenet_layer_scheduler
  import lenet_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LAYERS     = DefNumLayers,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned TIMEOUT_W      = DefTimeoutW,
  parameter int unsigned FRAME_CNT_W    = DefFrameCntW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  output logic [NUM_LAYERS-1:0]  layer_enable,
  input  logic [NUM_LAYERS-1:0]  layer_finished,
  output logic [NUM_LAYERS-1:0]  layer_reply,
  output logic                   result_valid,
  input  logic                   result_ack,
  input  logic                   clear_error,
  output logic                   busy,
  output logic                   error,
  output logic [2:0]             error_layer,
  output logic [FRAME_CNT_W-1:0] frames_done
);

  stage_state_e            stage_state [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]   go_start, release_hold, stage_enable, timeout;
  logic [MaxLayers-1:0]    timeout_vec;
  logic                    error_q;
  logic [LayerIdxW-1:0]    error_layer_q;
  logic [FRAME_CNT_W-1:0]  frames_done_q;
  logic                    last_hold;

  // Gated by reset directly so the host never sees ready while reset is held.
  assign frame_ready = reset && (stage_state[0] == StIdle) && !error_q;
  assign last_hold   = (stage_state[NUM_LAYERS-1] == StHold);

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign go_start[k] = frame_valid && frame_ready;
    end else begin : g_chain
      assign go_start[k] = (stage_state[k-1] == StHold) && (stage_state[k] == StIdle);
    end

    if (k == NUM_LAYERS - 1) begin : g_last
      assign release_hold[k] = result_ack;
    end else begin : g_mid
      assign release_hold[k] = (stage_state[k+1] == StIdle);
    end

    layer_stage_ctrl #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMEOUT_W      (TIMEOUT_W),
      .IS_LAST        (k == NUM_LAYERS - 1)
    ) u_stage (
      .clk          (clk),
      .reset        (reset),
      .go_start     (go_start[k]),
      .finished     (layer_finished[k]),
      .release_hold (release_hold[k]),
      .freeze       (error_q),
      .force_reply  (error_q && clear_error),
      .state        (stage_state[k]),
      .enable       (stage_enable[k]),
      .reply        (layer_reply[k]),
      .timeout      (timeout[k])
    );
  end

  always_comb begin
    timeout_vec = '0;
    timeout_vec[NUM_LAYERS-1:0] = timeout;
    busy = 1'b0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (stage_state[k] != StIdle) busy = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_q       <= 1'b0;
      error_layer_q <= '0;
      frames_done_q <= '0;
    end else begin
      if (error_q) begin
        if (clear_error) error_q <= 1'b0;
      end else if (|timeout) begin
        error_q       <= 1'b1;
        error_layer_q <= lowest_set(timeout_vec);
      end
      if (!error_q && last_hold && result_ack) frames_done_q <= frames_done_q + 1'b1;
    end
  end

  assign layer_enable = stage_enable & {NUM_LAYERS{!error_q}};
  assign result_valid = last_hold;
  assign error        = error_q;
  assign error_layer  = error_layer_q;
  assign frames_done  = frames_done_q;

endmodule

// File: tb/tb_lenet_layer_scheduler.sv
// Scoreboard bench: stub layers finish 10 cycles after enable; expected pulses are queued.
module tb_lenet_layer_scheduler;

  localparam int NL = 4;

  typedef struct {
    int kind;  // 0 enable, 1 reply, 2 result consumed (idx = frames_done)
    int idx;
    int cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_valid, frame_ready;
  logic [NL-1:0] layer_enable, layer_finished, layer_reply;
  logic          result_valid, result_ack, clear_error, busy, error;
  logic [2:0]    error_layer;
  logic [15:0]   frames_done;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_err = 0;
  ev_t exp_q[$];
  logic [3:0] stub_cnt [NL];
  logic [NL-1:0] stuck;

  lenet_layer_scheduler #(
    .NUM_LAYERS     (NL),
    .TIMEOUT_CYCLES (16),
    .TIMEOUT_W      (5),
    .FRAME_CNT_W    (16)
  ) dut (
    .clk            (clk),
    .reset          (rst_n),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .layer_enable   (layer_enable),
    .layer_finished (layer_finished),
    .layer_reply    (layer_reply),
    .result_valid   (result_valid),
    .result_ack     (result_ack),
    .clear_error    (clear_error),
    .busy           (busy),
    .error          (error),
    .error_layer    (error_layer),
    .frames_done    (frames_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub layers: finished from the 10th cycle after enable until replied.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NL; k++) begin
      if (!rst_n) stub_cnt[k] <= '0;
      else if (layer_reply[k]) stub_cnt[k] <= '0;
      else if (layer_enable[k]) stub_cnt[k] <= 4'd1;
      else if (stub_cnt[k] != 0 && stub_cnt[k] < 10) stub_cnt[k] <= stub_cnt[k] + 4'd1;
    end
  end

  always_comb begin
    for (int k = 0; k < NL; k++) layer_finished[k] = (stub_cnt[k] == 4'd10) && !stuck[k];
  end

  function automatic void push(int kind, int idx, int c);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic observe(int kind, int idx);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected event: kind %0d idx %0d at cycle %0d, none expected",
               kind, idx, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.idx != idx || e.cyc != cyc) begin
        n_err++;
        $display("FAIL event: got kind %0d idx %0d cycle %0d, expected kind %0d idx %0d cycle %0d",
                 kind, idx, cyc, e.kind, e.idx, e.cyc);
      end
    end
  endtask

  // Monitor: every pulse the DUT presents is matched against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < NL; k++) if (layer_enable[k]) observe(0, k);
        for (int k = 0; k < NL; k++) if (layer_reply[k]) observe(1, k);
        if (result_valid && result_ack) observe(2, int'(frames_done));
      end
    end
  end

  task automatic goto(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, " frame_ready"}, 32'(frame_ready), 0);
    check({tag, " layer_enable"}, 32'(layer_enable), 0);
    check({tag, " layer_reply"}, 32'(layer_reply), 0);
    check({tag, " result_valid"}, 32'(result_valid), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " error"}, 32'(error), 0);
    check({tag, " error_layer"}, 32'(error_layer), 0);
    check({tag, " frames_done"}, 32'(frames_done), 0);
  endtask

  initial begin
    int t, b, c, a;
    rst_n = 1'b0;
    frame_valid = 1'b0;
    result_ack = 1'b0;
    clear_error = 1'b0;
    stuck = '0;
    #2;
    check_all_zero("reset");
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready after reset", 32'(frame_ready), 1);

    // Single frame through all four layers, ack held high.
    goto(cyc + 2);
    t = cyc;
    b = t + 1;
    frame_valid = 1'b1;
    result_ack = 1'b1;
    push(0, 0, b);      push(0, 1, b + 12); push(1, 0, b + 13);
    push(0, 2, b + 24); push(1, 1, b + 25); push(0, 3, b + 36);
    push(1, 2, b + 37); push(2, 0, b + 47); push(1, 3, b + 48);
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    goto(b + 55);
    check("single frames_done", 32'(frames_done), 1);
    check("single busy", 32'(busy), 0);
    check("single ready", 32'(frame_ready), 1);
    check("single queue drained", 32'(exp_q.size()), 0);

    // Stray ack while no result is valid.
    result_ack = 1'b0;
    @(posedge clk);
    #1;
    result_ack = 1'b1;
    @(posedge clk);
    #1;
    result_ack = 1'b0;
    goto(cyc + 5);
    check("stray ack frames_done", 32'(frames_done), 1);

    // Layer 2 stuck: watchdog fires, then clear_error replies to busy stages.
    stuck[2] = 1'b1;
    t = cyc;
    b = t + 1;
    frame_valid = 1'b1;
    push(0, 0, b);      push(0, 1, b + 12); push(1, 0, b + 13); push(0, 0, b + 15);
    push(0, 2, b + 24); push(1, 1, b + 25); push(0, 1, b + 27); push(1, 0, b + 28);
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    goto(b + 14);
    frame_valid = 1'b1;
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    goto(b + 40);
    check("timeout not yet", 32'(error), 0);
    goto(b + 41);
    check("timeout error", 32'(error), 1);
    goto(b + 45);
    check("timeout error_layer", 32'(error_layer), 2);
    check("timeout ready", 32'(frame_ready), 0);
    check("timeout enables", 32'(layer_enable), 0);
    check("timeout busy", 32'(busy), 1);
    c = b + 50;
    goto(c);
    push(1, 1, c + 1);
    push(1, 2, c + 1);
    clear_error = 1'b1;
    @(posedge clk);
    #1;
    clear_error = 1'b0;
    check("clear error", 32'(error), 0);
    goto(c + 3);
    stuck[2] = 1'b0;
    check("clear ready", 32'(frame_ready), 1);
    check("clear busy", 32'(busy), 0);
    check("clear frames_done", 32'(frames_done), 1);
    check("clear queue drained", 32'(exp_q.size()), 0);

    // Asynchronous reset while stages 0 and 1 are both running.
    t = cyc;
    b = t + 1;
    frame_valid = 1'b1;
    push(0, 0, b); push(0, 1, b + 12); push(1, 0, b + 13); push(0, 0, b + 15);
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    goto(b + 14);
    frame_valid = 1'b1;
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    goto(b + 18);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post reset ready", 32'(frame_ready), 1);
    check("post reset frames_done", 32'(frames_done), 0);
    check("post reset queue drained", 32'(exp_q.size()), 0);

    // Back-pressure: four frames fill the chain, then drain with one more frame queued.
    t = cyc;
    frame_valid = 1'b1;
    push(0, 0, t + 1);  push(0, 1, t + 13); push(1, 0, t + 14); push(0, 0, t + 16);
    push(0, 2, t + 25); push(1, 1, t + 26); push(0, 1, t + 28); push(1, 0, t + 29);
    push(0, 0, t + 31); push(0, 3, t + 37); push(1, 2, t + 38); push(0, 2, t + 40);
    push(1, 1, t + 41); push(0, 1, t + 43); push(1, 0, t + 44); push(0, 0, t + 46);
    goto(t + 199);
    check("full ready", 32'(frame_ready), 0);
    check("full result_valid", 32'(result_valid), 1);
    check("full enables", 32'(layer_enable), 0);
    check("full queue drained", 32'(exp_q.size()), 0);
    a = t + 200;
    goto(a);
    result_ack = 1'b1;
    push(2, 0, a);      push(1, 3, a + 1);  push(0, 3, a + 3);  push(1, 2, a + 4);
    push(0, 2, a + 6);  push(1, 1, a + 7);  push(0, 1, a + 9);  push(1, 0, a + 10);
    push(0, 0, a + 12); push(2, 1, a + 14); push(1, 3, a + 15); push(0, 3, a + 18);
    push(1, 2, a + 19); push(0, 2, a + 21); push(1, 1, a + 22); push(0, 1, a + 24);
    push(1, 0, a + 25); push(2, 2, a + 29); push(1, 3, a + 30); push(0, 3, a + 33);
    push(1, 2, a + 34); push(0, 2, a + 36); push(1, 1, a + 37); push(2, 3, a + 44);
    push(1, 3, a + 45); push(0, 3, a + 48); push(1, 2, a + 49); push(2, 4, a + 59);
    push(1, 3, a + 60);
    goto(a + 12);
    frame_valid = 1'b0;
    goto(a + 50);
    check("drain four done", 32'(frames_done), 4);
    goto(a + 70);
    check("drain frames_done", 32'(frames_done), 5);
    check("drain busy", 32'(busy), 0);
    check("drain result_valid", 32'(result_valid), 0);
    check("drain queue drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lenet_layer_scheduler.md
Name: lenet_layer_scheduler

Overview:
Top-level sequencer for the LeNet layer chain (conv1 -> pool1 -> conv2 -> pool2 -> ...). Each layer engine uses the enable / finished_for_next_device / reply_from_next_device handshake. This block drives those handshakes for NUM_LAYERS engines so that up to NUM_LAYERS frames are in flight at once, one per layer. It also accepts frames from the host, presents final results, and detects stuck layers with a per-layer timeout.

Parameters:
NUM_LAYERS, 4, number of chained layer engines (2..8)
TIMEOUT_CYCLES, 4096, maximum cycles a layer may stay in RUN without asserting finished
TIMEOUT_W, 13, width of the timeout counter; must hold TIMEOUT_CYCLES
FRAME_CNT_W, 16, width of frames_done

Ports:
clk  in  1  the single clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
frame_valid  in  1  host offers a frame; image data held stable until frame_ready next rises
frame_ready  out  1  scheduler can accept a frame
layer_enable  out  NUM_LAYERS  one-cycle start pulse per layer; drives that layer's enable
layer_finished  in  NUM_LAYERS  finished_for_next_device from each layer
layer_reply  out  NUM_LAYERS  one-cycle release pulse; drives that layer's reply_from_next_device
result_valid  out  1  last layer's output is valid
result_ack  in  1  host has consumed the result
clear_error  in  1  pulse; recovers from the error state
busy  out  1  any stage not IDLE
error  out  1  sticky timeout flag
error_layer  out  3  index of the timed-out layer
frames_done  out  FRAME_CNT_W  count of completed frames

Behaviour:
- Reset (reset=0): takes effect immediately, mid-operation included.
  - All stages go to IDLE; all counters clear.
  - layer_enable, layer_reply, result_valid, busy, error, error_layer and frames_done are all 0.
  - frame_ready is 0 while reset is asserted and 1 in the first cycle after release.
- Per-stage FSM: IDLE, START, RUN, HOLD, XFER, REPLY. layer_enable[k] and layer_reply[k] are registered.
  - layer_enable[k] = 1 exactly when stage k is in START.
  - layer_reply[k] = 1 exactly when stage k is in REPLY.
- Transitions:
  - IDLE -> START: stage 0 on frame_valid & frame_ready. Stage k>0 when stage k-1 is in HOLD and stage k is IDLE, evaluated in the same cycle.
  - START -> RUN: unconditional, after 1 cycle.
  - RUN -> HOLD: when layer_finished[k]=1 is sampled in RUN. finished is ignored in START.
  - HOLD -> XFER (k<last): in the edge where stage k+1 leaves IDLE. XFER lasts 1 cycle, and stage k+1 is in START (enable high) during it.
  - XFER -> REPLY: after 1 cycle. The reply is thus asserted one cycle after the downstream enable, while the downstream layer is latching its input.
  - HOLD -> REPLY (last stage): on result_ack=1. The same edge increments frames_done, which wraps modulo 2^FRAME_CNT_W.
  - REPLY -> IDLE: after 1 cycle.
- Latency:
  - Frame accepted in cycle T: layer_enable[0] is high in T+1.
  - finished first sampled in cycle F: stage is in HOLD in F+1; the downstream enable is high in F+2 if downstream is IDLE; reply is high in F+3.
- Host signals:
  - result_valid = last stage in HOLD.
  - result_ack is ignored when result_valid=0.
  - frame_ready = (stage 0 IDLE) & !error.
  - busy = any stage != IDLE.
- Back-pressure: a stage stays in HOLD indefinitely while its downstream stage is not IDLE. The downstream stage is never enabled twice.
- Simultaneous events: each stage decides independently. A stage in HOLD and its upstream stage finishing in the same cycle cause no conflict, because the upstream only advances from HOLD once the downstream is IDLE.
- Timeout:
  - The counter clears on entry to RUN and increments each RUN cycle with finished=0.
  - At the edge ending the TIMEOUT_CYCLES-th such cycle: error is set, and error_layer = lowest timed-out index.
  - While error=1: every FSM freezes, layer_enable is forced to 0, frame_ready=0, and result_ack is ignored.
- clear_error (only while error=1): on the next edge, error clears and every non-IDLE stage goes to REPLY (one-cycle reply pulse), then IDLE. frames_done is unchanged.

Decomposition:
- Shared package lenet_ctrl_pkg:
  - stage state enum (IDLE..REPLY);
  - default NUM_LAYERS, TIMEOUT_CYCLES, FRAME_CNT_W;
  - the layer-index width constant.
- One sub-module, layer_stage_ctrl: per-stage FSM plus timeout counter. It is instantiated NUM_LAYERS times in a generate loop.
- The top level handles the host handshake, the inter-stage chaining, error priority and frames_done.

Test Plan:
- Single frame; stub layers (NUM_LAYERS=4) assert finished 10 cycles after enable until replied; result_ack held at 1 -> layer_enable[0] in T+1; each layer_reply[k] is exactly 1 cycle wide and one cycle after layer_enable[k+1]; frames_done=1; busy returns to 0.
- result_ack held at 0 for 200 cycles while frame_valid is held at 1 -> exactly 4 frames accepted, frame_ready=0, all stages in HOLD, no extra enables. Then ack 4 times -> frames_done=4 and results in order.
- TIMEOUT_CYCLES=16; layer 2 never finishes -> error=1 after 16 RUN cycles, error_layer=2, frame_ready=0, layer_enable all 0. Pulse clear_error -> reply pulses on every non-IDLE stage, error=0, frame_ready=1.
- reset driven to 0 asynchronously while stages 0 and 1 are in RUN -> all outputs 0 before the next clock edge; after release frame_ready=1 and frames_done=0.
- result_ack pulsed while result_valid=0 -> frames_done unchanged and no layer_reply.
- frame_valid asserted while stage 0 is in HOLD with stage 1 busy -> not accepted until stage 0 passes REPLY; then layer_enable[0] occurs exactly once.
